// File: rtl/i2c_controller_slave_pkg.sv
// I2C target shared types: FSM states, bus bit encodings
// and the address-match helper.
`timescale 1ns/1ps
package i2c_controller_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

    function automatic logic addr_hit(
        input logic [6:0] addr,
        input logic [6:0] own
    );
        return (addr == own) && (addr != GEN_CALL_ADDR);
    endfunction

endpackage

// File: rtl/i2c_controller_slave_line_filter.sv
// Bus line conditioner: 2-FF synchronizer, run-length glitch
// filter and single-clk rise/fall pulses on the filtered level.
`timescale 1ns/1ps
module i2c_controller_slave_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Idle bus is high, so everything resets to 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= line;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= s2;
                rise  <= s2;
                fall  <= ~s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_controller_slave.sv
// I2C target endpoint: START/STOP detect, 7-bit address match,
// byte receive/transmit with SCL stretching on an empty tx register.
`timescale 1ns/1ps
module i2c_controller_slave
    import i2c_controller_slave_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR   = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  wire        scl,
    inout  wire        sda,
    input  logic       rx_ack_en,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det,
    output logic       nack_det
);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] tx_hold;
    logic       tx_pend;
    logic       ack_en_q;
    logic       fall_d;
    logic       sda_oe;
    logic       scl_oe;

    logic scl_lvl, scl_r, scl_f;
    logic sda_lvl, sda_r, sda_f;
    logic bus_start, bus_stop, tx_take;

    i2c_controller_slave_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (scl),
        .level   (scl_lvl),
        .rise    (scl_r),
        .fall    (scl_f)
    );

    i2c_controller_slave_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (sda),
        .level   (sda_lvl),
        .rise    (sda_r),
        .fall    (sda_f)
    );

    // SCL must be high both before and after the sample for a bus condition.
    assign bus_start = sda_f & scl_lvl & ~scl_r;
    assign bus_stop  = sda_r & scl_lvl & ~scl_r;
    assign tx_take   = (state == ST_TX_BYTE) & tx_pend & tx_full
                     & ~bus_start & ~bus_stop;

    assign scl = scl_oe ? 1'b0 : 1'bz;
    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_hold   <= '0;
            tx_full   <= 1'b0;
            tx_pend   <= 1'b0;
            ack_en_q  <= 1'b0;
            fall_d    <= 1'b0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rw        <= 1'b0;
            addressed <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_det  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_det  <= 1'b0;
            fall_d    <= scl_f;

            // SDA moves one clk after SCL fall to keep hold margin.
            if (fall_d) begin
                sda_oe <= ((state == ST_ADDR_ACK) && (bit_cnt == 3'd1))
                       || ((state == ST_RX_ACK) && (bit_cnt == 3'd1) && ack_en_q)
                       || ((state == ST_TX_BYTE) && !tx_pend && !shift[7]);
            end

            if (bus_start) begin
                state     <= ST_ADDR;
                bit_cnt   <= '0;
                addressed <= 1'b0;
                start_det <= 1'b1;
                sda_oe    <= 1'b0;
                scl_oe    <= 1'b0;
                tx_pend   <= 1'b0;
            end else if (bus_stop) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                addressed <= 1'b0;
                stop_det  <= 1'b1;
                sda_oe    <= 1'b0;
                scl_oe    <= 1'b0;
                tx_pend   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_r) begin
                        shift   <= {shift[6:0], sda_lvl};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_hit(shift[6:0], OWN_ADDR)) begin
                                state     <= ST_ADDR_ACK;
                                rw        <= sda_lvl;
                                addressed <= 1'b1;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: if (scl_f) begin
                        if (bit_cnt == 3'd0) begin
                            bit_cnt <= 3'd1;
                        end else begin
                            bit_cnt <= '0;
                            tx_pend <= rw;
                            state   <= rw ? ST_TX_BYTE : ST_RX_BYTE;
                        end
                    end
                    ST_RX_BYTE: if (scl_r) begin
                        shift   <= {shift[6:0], sda_lvl};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {shift[6:0], sda_lvl};
                            rx_valid <= 1'b1;
                            ack_en_q <= rx_ack_en;
                            state    <= ST_RX_ACK;
                        end
                    end
                    ST_RX_ACK: if (scl_f) begin
                        if (bit_cnt == 3'd0) begin
                            bit_cnt <= 3'd1;
                        end else begin
                            bit_cnt <= '0;
                            state   <= ST_RX_BYTE;
                        end
                    end
                    ST_TX_BYTE: if (tx_pend) begin
                        if (tx_full) begin
                            shift   <= tx_hold;
                            tx_full <= 1'b0;
                            tx_pend <= 1'b0;
                            sda_oe  <= ~tx_hold[7];
                        end else begin
                            scl_oe <= 1'b1;
                        end
                    end else begin
                        // Release the stretch one clk after the shifter load.
                        if (scl_oe) scl_oe <= 1'b0;
                        if (scl_f) begin
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= ST_TX_ACK;
                        end
                    end
                    ST_TX_ACK: if (scl_r) begin
                        if (sda_lvl == I2C_ACK) begin
                            bit_cnt <= 3'd1;
                        end else begin
                            nack_det <= 1'b1;
                            state    <= ST_WAIT_STOP;
                        end
                    end else if (scl_f && (bit_cnt == 3'd1)) begin
                        bit_cnt <= '0;
                        tx_pend <= 1'b1;
                        state   <= ST_TX_BYTE;
                    end
                    ST_IDLE, ST_WAIT_STOP: ;
                    default: state <= ST_IDLE;
                endcase
            end

            if (tx_load && (!tx_full || tx_take)) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_controller_slave.sv
// Bench for i2c_controller_slave: bit-banged master on a pulled-up
// bus, event scoreboard for the DUT status pulses.
`timescale 1ns/1ps
module tb_i2c_controller_slave;

    localparam int Q = 10;

    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_STOP  = 2'd1;
    localparam logic [1:0] K_RX    = 2'd2;
    localparam logic [1:0] K_NACK  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl_low = 1'b0;
    logic       m_sda_low = 1'b0;
    logic       rx_ack_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_full, rx_valid, rw, addressed;
    logic       start_det, stop_det, nack_det;
    logic [7:0] rx_data;
    wire        scl_w, sda_w;

    int  n_chk = 0;
    int  n_pass = 0;
    int  start_cnt = 0;
    bit  stretch_seen = 0;
    bit  sda_seen = 0;
    ev_t exp_q[$];

    assign scl_w = m_scl_low ? 1'b0 : 1'bz;
    assign sda_w = m_sda_low ? 1'b0 : 1'bz;
    pullup (scl_w);
    pullup (sda_w);

    always #5 clk = ~clk;

    i2c_controller_slave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (scl_w),
        .sda       (sda_w),
        .rx_ack_en (rx_ack_en),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_full   (tx_full),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rw        (rw),
        .addressed (addressed),
        .start_det (start_det),
        .stop_det  (stop_det),
        .nack_det  (nack_det)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] d);
        exp_q.push_back('{kind: k, data: d});
    endtask

    task automatic pop_chk(input string name, input logic [1:0] k,
                           input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: unexpected event %0h/%0h, required none", name, k, d);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 32'(k), 32'(e.kind));
            chk({name, "_data"}, 32'(d), 32'(e.data));
        end
    endtask

    // Scoreboard monitor: each DUT pulse consumes one expected event.
    always @(negedge clk) begin
        if (reset_n) begin
            if (start_det) begin
                start_cnt++;
                pop_chk("start_det", K_START, 8'h00);
            end
            if (rx_valid) pop_chk("rx_valid", K_RX, rx_data);
            if (nack_det) pop_chk("nack_det", K_NACK, 8'h00);
            if (stop_det) pop_chk("stop_det", K_STOP, 8'h00);
        end
    end

    // Bus watcher: line low while the master releases it means DUT drive.
    always begin
        @(posedge clk);
        #1;
        if (scl_w === 1'b0 && !m_scl_low) stretch_seen = 1;
        if (sda_w === 1'b0 && !m_sda_low) sda_seen = 1;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        for (int i = 0; i < 4000 && scl_w !== 1'b1; i++) @(negedge clk);
        if (scl_w !== 1'b1) begin
            n_chk++;
            $display("FAIL scl_timeout: scl %b, required 1", scl_w);
        end
    endtask

    task automatic bit_out(input logic b);
        m_sda_low = !b;
        wclk(Q);
        m_scl_low = 0;
        wait_scl_high();
        wclk(Q);
        m_scl_low = 1;
        wclk(Q);
    endtask

    task automatic bit_in(output logic b);
        m_sda_low = 0;
        wclk(Q);
        m_scl_low = 0;
        wait_scl_high();
        wclk(Q);
        b = sda_w;
        m_scl_low = 1;
        wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(ack);
        m_sda_low = 0;
    endtask

    task automatic bus_start();
        m_sda_low = 1;
        wclk(Q);
        m_scl_low = 1;
        wclk(Q);
    endtask

    task automatic bus_rstart();
        m_sda_low = 0;
        wclk(Q);
        m_scl_low = 0;
        wait_scl_high();
        wclk(Q);
        m_sda_low = 1;
        wclk(Q);
        m_scl_low = 1;
        wclk(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1;
        wclk(Q);
        m_scl_low = 0;
        wait_scl_high();
        wclk(Q);
        m_sda_low = 0;
        wclk(2 * Q);
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1;
        @(negedge clk);
        tx_load = 0;
    endtask

    logic       ack;
    logic [7:0] d;
    int         sc0;

    initial begin
        wclk(5);
        chk("rst_outs", {tx_full, rx_valid, rw, addressed,
                         start_det, stop_det, nack_det}, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_bus", {scl_w, sda_w}, 2'b11);
        reset_n = 1;
        wclk(10);

        // Write 0xA5, 0x3C to own address.
        push(K_START, 0);
        bus_start();
        write_byte(8'h84, ack);
        chk("w_addr_ack", ack, 0);
        chk("w_addressed", addressed, 1);
        chk("w_rw", rw, 0);
        push(K_RX, 8'hA5);
        write_byte(8'hA5, ack);
        chk("w_ack_a5", ack, 0);
        push(K_RX, 8'h3C);
        write_byte(8'h3C, ack);
        chk("w_ack_3c", ack, 0);
        push(K_STOP, 0);
        bus_stop();
        chk("w_addressed_stop", addressed, 0);
        chk("w_rx_held", rx_data, 8'h3C);

        // Foreign address.
        push(K_START, 0);
        bus_start();
        sda_seen = 0;
        write_byte(8'h86, ack);
        chk("mis_nack", ack, 1);
        chk("mis_addressed", addressed, 0);
        push(K_STOP, 0);
        bus_stop();
        chk("mis_sda_undriven", sda_seen, 0);

        // Read with preload, then stretch until tx_load.
        load_tx(8'h5A);
        chk("pre_tx_full", tx_full, 1);
        push(K_START, 0);
        bus_start();
        write_byte(8'h85, ack);
        chk("r_addr_ack", ack, 0);
        chk("r_rw", rw, 1);
        stretch_seen = 0;
        read_byte(1'b0, d);
        chk("r_byte0", d, 8'h5A);
        chk("r_no_stretch", stretch_seen, 0);
        chk("r_tx_empty", tx_full, 0);
        push(K_NACK, 0);
        fork
            read_byte(1'b1, d);
            begin
                for (int i = 0; i < 2000 && !stretch_seen; i++) @(negedge clk);
                if (!stretch_seen) begin
                    n_chk++;
                    $display("FAIL stretch_timeout: stretch 0, required 1");
                end
                wclk(20);
                load_tx(8'hC3);
            end
        join
        chk("r_stretch", stretch_seen, 1);
        chk("r_byte1", d, 8'hC3);
        push(K_STOP, 0);
        bus_stop();

        // Data NACK with rx_ack_en low.
        push(K_START, 0);
        bus_start();
        rx_ack_en = 0;
        write_byte(8'h84, ack);
        chk("n_addr_ack", ack, 0);
        push(K_RX, 8'h11);
        write_byte(8'h11, ack);
        chk("n_data_nack", ack, 1);
        push(K_STOP, 0);
        bus_stop();
        rx_ack_en = 1;
        chk("n_rx_data", rx_data, 8'h11);

        // Repeated START turning a write into a read.
        push(K_START, 0);
        bus_start();
        write_byte(8'h84, ack);
        push(K_RX, 8'h77);
        write_byte(8'h77, ack);
        chk("rs_ack_77", ack, 0);
        chk("rs_rw_w", rw, 0);
        load_tx(8'h99);
        push(K_START, 0);
        bus_rstart();
        chk("rs_addressed_clr", addressed, 0);
        write_byte(8'h85, ack);
        chk("rs_addr_ack", ack, 0);
        chk("rs_rw_r", rw, 1);
        push(K_NACK, 0);
        read_byte(1'b1, d);
        chk("rs_byte", d, 8'h99);
        push(K_STOP, 0);
        bus_stop();

        // Short SDA glitches while SCL high.
        sc0 = start_cnt;
        @(negedge clk) m_sda_low = 1;
        @(negedge clk) m_sda_low = 0;
        wclk(30);
        @(negedge clk) m_sda_low = 1;
        wclk(2);
        m_sda_low = 0;
        wclk(30);
        chk("glitch_no_start", start_cnt, sc0);

        // Reset in the middle of a transmitted byte.
        load_tx(8'h0F);
        push(K_START, 0);
        bus_start();
        write_byte(8'h85, ack);
        chk("rr_addr_ack", ack, 0);
        bit_in(ack);
        chk("rr_bit7", ack, 0);
        load_tx(8'h77);
        m_sda_low = 0;
        wclk(Q);
        m_scl_low = 0;
        wait_scl_high();
        wclk(2);
        chk("rr_sda_driven", sda_w, 0);
        #2 reset_n = 0;
        #1;
        chk("rr_bus_released", {scl_w, sda_w}, 2'b11);
        chk("rr_state_clr", {tx_full, addressed, rw}, 0);
        wclk(5);
        reset_n = 1;
        wclk(20);

        // Recovery transfer after the reset.
        push(K_START, 0);
        bus_start();
        write_byte(8'h84, ack);
        chk("rec_addr_ack", ack, 0);
        push(K_RX, 8'h5C);
        write_byte(8'h5C, ack);
        chk("rec_ack", ack, 0);
        push(K_STOP, 0);
        bus_stop();

        wclk(10);
        chk("events_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
